fetch_pc_unit: RTL
==================

# fetch_pc_unit

Program-counter register and instruction-fetch sequencer for the RISC core. It sits directly downstream of the next-PC Mux: the Mux output (sequential PC or branch/jump target) arrives on `redirect_pc`. The block issues one instruction-memory request at a time, tracks the in-flight request, and discards responses made stale by a redirect. It presents `{pc, instruction}` pairs to decode through a valid/ready handshake.

## Interface
- `XLEN`, 32, address/data width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `INSTR_BYTES`, 4, PC increment per fetch
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  suppress issue of new requests; in-flight request unaffected
- `redirect_valid`  in  1  load new PC this cycle
- `redirect_pc`  in  XLEN  target from next-PC Mux; bits [1:0] forced to 0 on load
- `req_valid`  out  1  instruction-memory request
- `req_addr`  out  XLEN  request address (= current PC)
- `req_ready`  in  1  memory accepts request
- `rsp_valid`  in  1  memory response strobe (single cycle)
- `rsp_data`  in  XLEN  fetched instruction
- `out_valid`  out  1  decode-side valid
- `out_pc`  out  XLEN  PC of presented instruction
- `out_instr`  out  XLEN  presented instruction
- `out_ready`  in  1  decode accepts

## Operation
- Registers: `pc`, `inflight_pc`, `out_pc`, `out_instr`, `out_valid`, state.
- States:
  - IDLE: may issue.
  - WAIT_RSP: one request outstanding.
  - HOLD: output occupied, waiting on `out_ready`.
  - DRAIN: outstanding response is stale and must be discarded.
- IDLE: `req_valid = !stall && !redirect_valid`, `req_addr = pc`.
  - On `req_valid && req_ready`: `inflight_pc <= pc`, `pc <= pc + INSTR_BYTES` (mod 2^XLEN), then WAIT_RSP.
- WAIT_RSP: on `rsp_valid`, `out_instr <= rsp_data`, `out_pc <= inflight_pc`, `out_valid <= 1`, then HOLD.
- HOLD: on `out_ready`, `out_valid <= 0`, then IDLE. No request is issued in HOLD.
- DRAIN: on `rsp_valid`, discard the response, then IDLE.
- Redirect is the highest priority in every state:
  - `pc <= {redirect_pc[XLEN-1:2], 2'b00}`; `out_valid <= 0`.
  - From IDLE or HOLD: go to IDLE.
  - From WAIT_RSP with no `rsp_valid` in the same cycle: go to DRAIN.
  - From WAIT_RSP with `rsp_valid` in the same cycle: drop the response, go to IDLE.
  - From DRAIN with `rsp_valid` in the same cycle: go to IDLE. Without it: stay in DRAIN; `pc` takes the latest target.
- `stall` gates only issue from IDLE. It never blocks responses, drains or redirects.
- `rsp_valid` in IDLE or HOLD is a protocol violation and is ignored. A bench assertion flags it.

## Timing
- Reset (asynchronous): `pc = RESET_PC`, state IDLE, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`, `inflight_pc = 0`.
  - `req_valid` is 0 while `rst_n` is low.
  - First request is issued in the first cycle after deassertion.
- Reset mid-operation aborts any outstanding request. Any later response lands in IDLE and is ignored.
- Request to output latency:
  - `out_valid` rises the cycle after `rsp_valid`.
  - With 1-cycle memory, minimum issue period is 3 cycles (IDLE, WAIT_RSP, HOLD with `out_ready` held high).
- `req_valid` and `req_addr` are combinational from state, `pc`, `stall` and `redirect_valid`. All other outputs are registered.
- Redirect takes effect on the next edge. The next `req_addr` equals the aligned target.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` (IDLE, WAIT_RSP, HOLD, DRAIN)
  - `INSTR_BYTES_DEFAULT`
  - `PC_ALIGN_MASK`
- Single module, no sub-module: the PC incrementer is one adder. The existing Mux remains upstream and is not instantiated here.

## Test plan
- Reset, then `req_ready = 1`, memory returns `rsp_data = 32'h00500093` one cycle after each request, `out_ready = 1`:
  - `req_addr` sequence is 0x0, 0x4, 0x8.
  - First output is `out_pc = 0x0`, `out_instr = 32'h00500093`.
- `stall = 1` for 5 cycles while in IDLE: `req_valid` stays 0 and `pc` is unchanged. On release, the request goes to the same address.
- Redirect to 32'h0000_0103 while WAIT_RSP for PC 0x8:
  - Next `req_addr` is 0x100.
  - The late response for 0x8 is discarded, and `out_valid` never shows `out_pc = 0x8`.
- `rsp_valid` and `redirect_valid` (target 0x200) in the same cycle: no output is produced, state goes to IDLE, next `req_addr` is 0x200.
- `out_ready = 0` for 4 cycles in HOLD: `out_pc` and `out_instr` stay stable, no new request is issued, and output retires on the cycle `out_ready` rises.
- `rst_n` pulsed low during WAIT_RSP: outputs reset immediately, next `req_addr` is `RESET_PC`, and the stray response is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch PC unit.
//   fetch_state_t       - sequencer states (IDLE, WAIT_RSP, HOLD, DRAIN)
//   INSTR_BYTES_DEFAULT - default PC increment per fetch
//   PC_ALIGN_MASK       - low PC bits forced to zero when a redirect is loaded
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        HOLD     = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES_DEFAULT = 4;
    localparam logic [1:0]  PC_ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program-counter register and single-outstanding instruction
// fetch sequencer. Issues one memory request at a time from the current PC,
// drops responses made stale by a redirect, and presents {pc, instruction}
// to decode through a valid/ready handshake.
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   stall                  - blocks issue of new requests from IDLE only
//   redirect_valid/_pc     - load a new (word-aligned) PC, highest priority
//   req_valid/_addr/_ready - instruction-memory request (combinational)
//   rsp_valid/_data        - single-cycle memory response
//   out_valid/_pc/_instr   - registered decode-side output
//   out_ready              - decode accepts the presented instruction
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int unsigned      INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready
);

    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_KEEP = ~XLEN'(PC_ALIGN_MASK);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic            out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            out_valid_q   <= out_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        out_valid_d   = out_valid_q;
        // Gated by rst_n so no request is advertised while reset is held.
        req_valid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_valid = rst_n && !stall && !redirect_valid;
                if (req_valid && req_ready) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + PC_INC;
                    state_d       = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    out_instr_d = rsp_data;
                    out_pc_d    = inflight_pc_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above; a response arriving in the same
        // cycle is dropped, otherwise a pending response must be drained.
        if (redirect_valid) begin
            pc_d        = redirect_pc & ALIGN_KEEP;
            out_valid_d = 1'b0;
            out_pc_d    = out_pc_q;
            out_instr_d = out_instr_q;
            if ((state_q == WAIT_RSP || state_q == DRAIN) && !rsp_valid) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign req_addr  = pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule
